aplic_msi_tx: RTL

AXI write initiator that turns interrupt-delivery requests (hart, interrupt file, EIID) into MSI writes targeting IMSIC interrupt-file `seteipnum` registers. It sits between the APLIC MSI-mode delivery logic and the system interconnect, on the opposite end of the link terminated by the IMSIC register map. Requests are buffered in a small FIFO and issued one outstanding AXI write at a time. Addresses use the same layout the IMSIC decodes: M-files per hart, S/VS-files grouped per hart.

---
 rtl/aplic_msi_tx.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/aplic_msi_tx.sv
// aplic_msi_tx: queues APLIC MSI delivery requests and issues each one as a single-beat AXI write
// to an IMSIC seteipnum register. Define APLIC_MSI_TX_RETRY_EN to retry failed writes up to 3 times.
package aplic_msi_tx_pkg;

    typedef struct packed {
        int unsigned NrHarts;
        int unsigned NrHartsW;
        int unsigned NrInptFiles;
        int unsigned NrSourcesW;
        logic [31:0] InptFilesMAddr;
        logic [31:0] InptFilesSAddr;
    } imsic_cfg_t;

    typedef struct packed {
        int unsigned AXI_ADDR_WIDTH;
        int unsigned AXI_DATA_WIDTH;
        int unsigned AXI_ID_WIDTH;
    } protocol_cfg_t;

    localparam imsic_cfg_t DefaultImsicCfg = '{
        NrHarts: 2, NrHartsW: 2, NrInptFiles: 3, NrSourcesW: 11,
        InptFilesMAddr: 32'h2400_0000, InptFilesSAddr: 32'h2800_0000
    };

    localparam protocol_cfg_t DefaultImsicProtocolCfg = '{
        AXI_ADDR_WIDTH: 64, AXI_DATA_WIDTH: 64, AXI_ID_WIDTH: 4
    };

    localparam int unsigned AxiAddrW = 64;
    localparam int unsigned AxiDataW = 64;
    localparam int unsigned AxiIdW   = 4;
    localparam int unsigned AxiStrbW = AxiDataW / 8;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [AxiAddrW-1:0] addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
        logic                lock;
        logic [3:0]          cache;
        logic [2:0]          prot;
        logic [3:0]          qos;
        logic [3:0]          region;
    } axi_ax_t;

    typedef struct packed {
        logic [AxiDataW-1:0] data;
        logic [AxiStrbW-1:0] strb;
        logic                last;
    } axi_w_t;

    typedef struct packed {
        logic [AxiIdW-1:0] id;
        logic [1:0]        resp;
    } axi_b_t;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [AxiDataW-1:0] data;
        logic [1:0]          resp;
        logic                last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } axi_resp_t;

endpackage

// Handshakes: every AXI valid is held, with address/data stable, until the matching ready is seen;
// a request on the MSI side is taken in any cycle where i_msi_valid && o_msi_ready.
module aplic_msi_tx #(
    parameter aplic_msi_tx_pkg::imsic_cfg_t    ImsicCfg    = aplic_msi_tx_pkg::DefaultImsicCfg,
    parameter aplic_msi_tx_pkg::protocol_cfg_t ProtocolCfg = aplic_msi_tx_pkg::DefaultImsicProtocolCfg,
    parameter type                             axi_req_t   = aplic_msi_tx_pkg::axi_req_t,
    parameter type                             axi_resp_t  = aplic_msi_tx_pkg::axi_resp_t,
    parameter int unsigned                     FifoDepth   = 4,
    parameter int unsigned                     AxiId       = 0
) (
    input  logic                                     i_clk,
    input  logic                                     ni_rst,
    input  logic                                     i_msi_valid,
    output logic                                     o_msi_ready,
    input  logic [ImsicCfg.NrHartsW-1:0]             i_msi_hart,
    input  logic [$clog2(ImsicCfg.NrInptFiles)-1:0]  i_msi_file,
    input  logic [ImsicCfg.NrSourcesW-1:0]           i_msi_eiid,
    output axi_req_t                                 o_req,
    input  axi_resp_t                                i_resp,
    output logic                                     o_busy,
    output logic                                     o_drop,
    output logic                                     o_err
);

    localparam int unsigned EiidW = ImsicCfg.NrSourcesW;
    localparam int unsigned PtrW  = $clog2(FifoDepth);
    localparam int unsigned AddrW = ProtocolCfg.AXI_ADDR_WIDTH;
    localparam int unsigned DataW = ProtocolCfg.AXI_DATA_WIDTH;
    localparam int unsigned IdW   = ProtocolCfg.AXI_ID_WIDTH;
    localparam int unsigned StrbW = DataW / 8;

    typedef struct packed {
        logic [31:0]      addr;
        logic [EiidW-1:0] eiid;
    } entry_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e          state_q;
    entry_t          fifo_q [FifoDepth];
    logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
    entry_t          hold_q;
    logic            aw_valid_q, w_valid_q, b_ready_q;
    logic            drop_q, err_q;
`ifdef APLIC_MSI_TX_RETRY_EN
    logic [1:0]      retry_cnt_q;
`endif

    logic [31:0]     hart_idx, file_idx, req_addr;
    logic            req_ok;
    entry_t          new_entry;
    logic            fifo_empty, fifo_full;
    logic            accept, push_ok, bypass, fifo_push, fifo_pop;
    logic            aw_done, w_done;

    assign hart_idx = 32'(i_msi_hart);
    assign file_idx = 32'(i_msi_file);

    // Address layout mirrors the IMSIC decode: one M-file page per hart, then S/VS pages grouped by hart.
    always_comb begin
        req_ok = (hart_idx < ImsicCfg.NrHarts) && (file_idx < ImsicCfg.NrInptFiles)
                 && (i_msi_eiid != '0);
        if (file_idx == 32'd0) begin
            req_addr = ImsicCfg.InptFilesMAddr + (hart_idx << 12);
        end else begin
            req_addr = ImsicCfg.InptFilesSAddr
                       + ((hart_idx * (ImsicCfg.NrInptFiles - 32'd1) + file_idx - 32'd1) << 12);
        end
    end

    assign new_entry  = '{addr: req_addr, eiid: i_msi_eiid};
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW])
                        && (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

    assign accept    = i_msi_valid && o_msi_ready;
    assign push_ok   = accept && req_ok;
    // An idle engine with nothing queued loads the new request straight into the holding register.
    assign bypass    = push_ok && fifo_empty && (state_q == StIdle);
    assign fifo_push = push_ok && !bypass;
    assign fifo_pop  = (state_q == StIdle) && !fifo_empty;

    assign aw_done = !aw_valid_q || i_resp.aw_ready;
    assign w_done  = !w_valid_q || i_resp.w_ready;

    always_ff @(posedge i_clk) begin
        if (fifo_push) begin
            fifo_q[wr_ptr_q[PtrW-1:0]] <= new_entry;
        end
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            hold_q      <= '0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            drop_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef APLIC_MSI_TX_RETRY_EN
            retry_cnt_q <= 2'd0;
`endif
        end else begin
            drop_q <= accept && !req_ok;
            if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

            case (state_q)
                StIdle: begin
                    if (fifo_pop || bypass) begin
                        hold_q      <= fifo_pop ? fifo_q[rd_ptr_q[PtrW-1:0]] : new_entry;
                        aw_valid_q  <= 1'b1;
                        w_valid_q   <= 1'b1;
                        state_q     <= StSend;
`ifdef APLIC_MSI_TX_RETRY_EN
                        retry_cnt_q <= 2'd0;
`endif
                    end
                end
                StSend: begin
                    if (i_resp.aw_ready) aw_valid_q <= 1'b0;
                    if (i_resp.w_ready)  w_valid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        b_ready_q <= 1'b1;
                        state_q   <= StResp;
                    end
                end
                StResp: begin
                    if (i_resp.b_valid) begin
                        b_ready_q <= 1'b0;
                        state_q   <= StIdle;
`ifdef APLIC_MSI_TX_RETRY_EN
                        if (i_resp.b.resp[1]) begin
                            if (retry_cnt_q == 2'd3) begin
                                err_q  <= 1'b1;
                                drop_q <= 1'b1;
                            end else begin
                                retry_cnt_q <= retry_cnt_q + 2'd1;
                                aw_valid_q  <= 1'b1;
                                w_valid_q   <= 1'b1;
                                state_q     <= StSend;
                            end
                        end else if (i_resp.b.resp != 2'b00) begin
                            err_q <= 1'b1;
                        end
`else
                        if (i_resp.b.resp != 2'b00) err_q <= 1'b1;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_msi_ready = !fifo_full;
    assign o_busy      = !fifo_empty || (state_q != StIdle);
    assign o_drop      = drop_q;
    assign o_err       = err_q;

    always_comb begin
        o_req          = '0;
        o_req.aw.id    = IdW'(AxiId);
        o_req.aw.addr  = AddrW'(hold_q.addr);
        o_req.aw.len   = 8'd0;
        o_req.aw.size  = 3'd2;
        o_req.aw.burst = 2'b01;
        o_req.aw_valid = aw_valid_q;
        o_req.w.data   = DataW'(hold_q.eiid);
        o_req.w.strb   = StrbW'(4'hF);
        o_req.w.last   = 1'b1;
        o_req.w_valid  = w_valid_q;
        o_req.b_ready  = b_ready_q;
        o_req.ar_valid = 1'b0;
        o_req.r_ready  = 1'b0;
    end

    logic unused_resp;
    assign unused_resp = ^{i_resp.ar_ready, i_resp.r_valid, i_resp.r, i_resp.b.id};

endmodule
